// File: rtl/uart_msg_parser.sv
// uart_msg_parser: byte-level receive parser for the host protocol.
// Frames length-prefixed messages (L, 00, 00, type, payload, CRC-32 LSB first),
// checks header, length and inter-byte timing, buffers the payload and hands
// each complete message to the command decoder with a valid/ready handshake.
// A lone 00 byte in IDLE is a PING.
// Build option: define MSG_CRC_CHECK_EN to instantiate and compare the CRC-32;
// without it the four CRC bytes are only counted and timed.
//
// state | meaning
// IDLE  | waiting for length byte or PING
// HDR   | receiving header bytes 1..3
// BODY  | receiving payload bytes into the buffer
// CRC   | receiving the four CRC bytes
// DONE  | message presented, waiting for msg_ready
module uart_msg_parser #(
    parameter int MAX_LEN        = 64,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int PAYLOAD_DEPTH  = MAX_LEN - 8
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [7:0]                       rx_byte,
    input  logic                             rx_valid,
    output logic                             ping,
    output logic                             msg_valid,
    input  logic                             msg_ready,
    output logic [7:0]                       msg_type,
    output logic [7:0]                       msg_len,
    input  logic [$clog2(PAYLOAD_DEPTH)-1:0] rd_addr,
    output logic [7:0]                       rd_data,
    output logic                             err,
    output logic [2:0]                       err_code
);
    localparam int AW = $clog2(PAYLOAD_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] E_BAD_LEN  = 3'd1;
    localparam logic [2:0] E_TIMEOUT  = 3'd2;
    localparam logic [2:0] E_BAD_CRC  = 3'd3;
    localparam logic [2:0] E_BAD_RSVD = 3'd4;
    localparam logic [2:0] E_OVERRUN  = 3'd5;

    typedef enum logic [2:0] {IDLE, HDR, BODY, CRC, DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    type_q, type_d;
    logic [7:0]    msg_len_q, msg_len_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ping_q, ping_d;
    logic          err_q, err_d;
    logic [2:0]    code_q, code_d;
    logic [AW-1:0] wp_q, wp_d;
    logic          we;
    logic [7:0]    rd_data_q;
    logic [7:0]    mem [PAYLOAD_DEPTH];

`ifdef MSG_CRC_CHECK_EN
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    logic [31:0] crc_q, crc_d;
    logic [31:0] crc_rx_q, crc_rx_d;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction
`endif

    // State register and all registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            type_q    <= '0;
            msg_len_q <= '0;
            tmo_q     <= '0;
            ping_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= '0;
            wp_q      <= '0;
`ifdef MSG_CRC_CHECK_EN
            crc_q     <= CRC_INIT;
            crc_rx_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            type_q    <= type_d;
            msg_len_q <= msg_len_d;
            tmo_q     <= tmo_d;
            ping_q    <= ping_d;
            err_q     <= err_d;
            code_q    <= code_d;
            wp_q      <= wp_d;
`ifdef MSG_CRC_CHECK_EN
            crc_q     <= crc_d;
            crc_rx_q  <= crc_rx_d;
`endif
        end
    end

    // Next-state logic: framing, header checks, timeout and handshake
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        type_d    = type_q;
        msg_len_d = msg_len_q;
        tmo_d     = '0;
        ping_d    = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;
        wp_d      = wp_q;
        we        = 1'b0;
`ifdef MSG_CRC_CHECK_EN
        crc_d     = crc_q;
        crc_rx_d  = crc_rx_q;
`endif
        unique case (state_q)
            IDLE: begin
                wp_d = '0;
`ifdef MSG_CRC_CHECK_EN
                crc_d = CRC_INIT;
`endif
                if (rx_valid) begin
                    if (rx_byte == 8'h00) begin
                        ping_d = 1'b1;
                    end else if (rx_byte >= 8'd8 && rx_byte <= MAX_LEN_B) begin
                        state_d = HDR;
                        cnt_d   = 8'd1;
                        len_d   = rx_byte;
`ifdef MSG_CRC_CHECK_EN
                        crc_d   = crc_step(CRC_INIT, rx_byte);
`endif
                    end else begin
                        err_d  = 1'b1;
                        code_d = E_BAD_LEN;
                    end
                end
            end
            HDR, BODY, CRC: begin
                if (rx_valid) begin
                    cnt_d = cnt_q + 8'd1;
                    if (state_q == HDR) begin
`ifdef MSG_CRC_CHECK_EN
                        crc_d = crc_step(crc_q, rx_byte);
`endif
                        if (cnt_q == 8'd3) begin
                            type_d  = rx_byte;
                            state_d = (len_q > 8'd8) ? BODY : CRC;
                        end else if (rx_byte != 8'h00) begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                            code_d  = E_BAD_RSVD;
`ifdef MSG_CRC_CHECK_EN
                            crc_d   = CRC_INIT;
`endif
                        end
                    end else if (state_q == BODY) begin
`ifdef MSG_CRC_CHECK_EN
                        crc_d = crc_step(crc_q, rx_byte);
`endif
                        we   = 1'b1;
                        wp_d = wp_q + 1'b1;
                        if (cnt_q == len_q - 8'd5)
                            state_d = CRC;
                    end else begin
`ifdef MSG_CRC_CHECK_EN
                        crc_rx_d = {rx_byte, crc_rx_q[31:8]};
`endif
                        if (cnt_q == len_q - 8'd1) begin
`ifdef MSG_CRC_CHECK_EN
                            if (crc_rx_d == ~crc_q) begin
                                state_d   = DONE;
                                msg_len_d = len_q - 8'd8;
                            end else begin
                                state_d = IDLE;
                                err_d   = 1'b1;
                                code_d  = E_BAD_CRC;
                                crc_d   = CRC_INIT;
                            end
`else
                            state_d   = DONE;
                            msg_len_d = len_q - 8'd8;
`endif
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    code_d  = E_TIMEOUT;
`ifdef MSG_CRC_CHECK_EN
                    crc_d   = CRC_INIT;
`endif
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DONE: begin
                // A byte arriving while the message is held is dropped, even
                // in the cycle the consumer accepts it.
                if (rx_valid) begin
                    err_d  = 1'b1;
                    code_d = E_OVERRUN;
                end
                if (msg_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Payload buffer write port
    always_ff @(posedge CLK) begin
        if (we)
            mem[wp_q] <= rx_byte;
    end

    // Registered payload read port
    always_ff @(posedge CLK) begin
        if (RST)
            rd_data_q <= '0;
        else
            rd_data_q <= mem[rd_addr];
    end

    assign ping      = ping_q;
    assign msg_valid = (state_q == DONE);
    assign msg_type  = type_q;
    assign msg_len   = msg_len_q;
    assign rd_data   = rd_data_q;
    assign err       = err_q;
    assign err_code  = code_q;
endmodule
